// File: rtl/ty_stream_pkg.sv
// Shared types, default sizes and width helper for the stream loader slice.
package ty_stream_pkg;

    localparam int DEF_DATAW   = 32;
    localparam int DEF_NINPUTS = 2;
    localparam int DEF_SIZE    = 1024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // Ceiling log2, never below 1 so derived vectors always have a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/ty_stream_loader_if.sv
// Memory read port plus outgoing stream handshake of the loader.
interface ty_stream_loader_if
    import ty_stream_pkg::*;
#(
    parameter int W  = DEF_DATAW * DEF_NINPUTS,
    parameter int AW = clog2(DEF_SIZE)
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_data;
    logic          m_tvalid;
    logic [W-1:0]  m_tdata;
    logic          m_tready;

    modport master (
        output mem_rd_en, mem_rd_addr, m_tvalid, m_tdata,
        input  mem_rd_data, m_tready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, m_tvalid, m_tdata,
        output mem_rd_data, m_tready
    );

endinterface

// File: rtl/ty_sync_fifo.sv
// Synchronous FIFO with combinational head read and an occupancy count.
module ty_sync_fifo
    import ty_stream_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int PW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [PW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ty_stream_loader.sv
// Streams NINPUTS side-by-side arrays from a fixed-latency memory to a kernel.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; address is always 0 here
// S_ISSUE | issuing reads while FIFO credit allows
// S_DRAIN | all reads issued; waiting for in-flight words and FIFO to empty
// S_DONE  | one-cycle done pulse, then back to idle
module ty_stream_loader
    import ty_stream_pkg::*;
#(
    parameter int DATAW   = DEF_DATAW,
    parameter int NINPUTS = DEF_NINPUTS,
    parameter int SIZE    = DEF_SIZE,
    parameter int RDLAT   = 2,
    parameter int FDEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_wi,
    output logic        busy,
    output logic        done,
    output logic [15:0] wi_count,
    ty_stream_loader_if.master bus
);
    localparam int W  = DATAW * NINPUTS;
    localparam int AW = clog2(SIZE);
    localparam int CW = clog2(FDEPTH) + 1;

    state_t          state, state_nx;
    logic [AW-1:0]   addr, addr_nx;
    logic [15:0]     wi_nx;
    logic [15:0]     num_lat, num_nx;
    logic [RDLAT-1:0] vld_sr;
    logic            rd_en;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_flight;
    logic [CW:0]     used;
    logic            credit_ok;

    // Reads already strobed whose data has not yet landed in the FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RDLAT; i++) begin
            in_flight = in_flight + (CW+1)'(vld_sr[i]);
        end
    end

    assign used      = {1'b0, fifo_count} + in_flight;
    assign credit_ok = (used < (CW+1)'(FDEPTH));

    // Next-state, read strobe and address/instance advance.
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        wi_nx    = wi_count;
        num_nx   = num_lat;
        rd_en    = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    wi_nx = '0;
                    if (num_wi == 16'd0) begin
                        state_nx = S_DONE;
                    end else begin
                        // FIFO is empty and address is 0 in idle, so the
                        // first read goes out in the start cycle itself.
                        num_nx   = num_wi;
                        rd_en    = 1'b1;
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_ISSUE: rd_en = credit_ok;
            S_DRAIN: begin
                if (fifo_empty && in_flight == '0) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (rd_en) begin
            if (addr == AW'(SIZE - 1)) begin
                addr_nx = '0;
                wi_nx   = wi_nx + 16'd1;
                if (wi_nx == num_nx) state_nx = S_DRAIN;
            end else begin
                addr_nx = addr + AW'(1);
            end
        end
    end

    // State and run registers; reset also drops every in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            wi_count <= '0;
            num_lat  <= '0;
            vld_sr   <= '0;
        end else begin
            state    <= state_nx;
            addr     <= addr_nx;
            wi_count <= wi_nx;
            num_lat  <= num_nx;
            for (int i = RDLAT - 1; i > 0; i--) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            vld_sr[0] <= rd_en;
        end
    end

    assign busy            = (state != S_IDLE);
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = addr;
    assign bus.m_tvalid    = !fifo_empty;

    ty_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_sr[RDLAT-1]),
        .din   (bus.mem_rd_data),
        .pop   (bus.m_tvalid && bus.m_tready),
        .dout  (bus.m_tdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ty_stream_loader.sv
// Scoreboard bench for ty_stream_loader with a fixed-latency memory model.
module tb_ty_stream_loader;
    import ty_stream_pkg::*;

    localparam int DATAW   = 32;
    localparam int NINPUTS = 2;
    localparam int SIZE    = 16;
    localparam int RDLAT   = 2;
    localparam int FDEPTH  = 8;
    localparam int W       = DATAW * NINPUTS;
    localparam int AW      = clog2(SIZE);

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_wi;
    logic        busy;
    logic        done;
    logic [15:0] wi_count;

    ty_stream_loader_if #(.W(W), .AW(AW)) bus ();

    ty_stream_loader #(
        .DATAW(DATAW), .NINPUTS(NINPUTS), .SIZE(SIZE), .RDLAT(RDLAT), .FDEPTH(FDEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_wi(num_wi),
        .busy(busy), .done(done), .wi_count(wi_count), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] got [256];
    int           rd_cnt, beat_cnt, max_out, hold_err;
    bit           prev_stall;
    logic [W-1:0] prev_data;

    function automatic logic [W-1:0] mem_word(input int a);
        logic [W-1:0] w;
        for (int k = 0; k < NINPUTS; k++) w[k*DATAW +: DATAW] = DATAW'(a + 1);
        return w;
    endfunction

    // Memory model: word for address a is a+1 in every array lane, RDLAT cycles late.
    logic [W-1:0] rdq [RDLAT];
    always @(posedge clk) begin
        for (int i = RDLAT - 1; i > 0; i--) rdq[i] <= rdq[i-1];
        rdq[0] <= bus.mem_rd_en ? mem_word(int'(bus.mem_rd_addr)) : '1;
    end
    assign bus.mem_rd_data = rdq[RDLAT-1];

    // Monitor: records beats, reads issued, outstanding depth and hold violations.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt = 0; beat_cnt = 0; max_out = 0; hold_err = 0; prev_stall = 0;
        end else begin
            if (bus.mem_rd_en) rd_cnt++;
            if (prev_stall && (!bus.m_tvalid || bus.m_tdata !== prev_data)) hold_err++;
            if (bus.m_tvalid && bus.m_tready) begin
                if (beat_cnt < 256) got[beat_cnt] = bus.m_tdata;
                beat_cnt++;
            end
            if (rd_cnt - beat_cnt > max_out) max_out = rd_cnt - beat_cnt;
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_data  = bus.m_tdata;
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; num_wi = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic push_exp(input int n);
        for (int w = 0; w < n; w++)
            for (int a = 0; a < SIZE; a++) exp_q.push_back(mem_word(a));
    endtask

    task automatic launch(input int n);
        @(posedge clk); #1;
        num_wi = 16'(n); start = 1'b1;
    endtask

    // mode 0: ready high, 1: ready toggles, 2: ready low
    task automatic wait_done(input int mode, input int max_cyc, output bit seen);
        seen = 0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) seen = 1;
            case (mode)
                0:       bus.m_tready = 1'b1;
                1:       bus.m_tready = ~bus.m_tready;
                default: bus.m_tready = 1'b0;
            endcase
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", bus.mem_rd_en); end
        checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bus.mem_rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.mem_rd_addr); end
        checks++; if (wi_count !== 16'd0) begin errors++; $display("FAIL reset_wi: got %0d expected 0", wi_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit seen;
        int lat;
        logic [W-1:0] e;
        apply_reset();
        bus.m_tready = 1'b1;
        push_exp(1);
        launch(1);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (bus.m_tvalid) lat = c;
        end
        checks++; if (lat !== RDLAT + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, RDLAT + 1); end
        wait_done(0, 100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL single_done: got timeout expected done pulse"); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (beat_cnt !== 16) begin errors++; $display("FAIL single_beats: got %0d expected 16", beat_cnt); end
        checks++; if (wi_count !== 16'd1) begin errors++; $display("FAIL single_wi: got %0d expected 1", wi_count); end
        for (int i = 0; i < beat_cnt && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL single_data[%0d]: got %0h expected %0h", i, got[i], e); end
        end
    endtask

    task automatic test_multi_toggle();
        bit seen;
        logic [W-1:0] e;
        apply_reset();
        bus.m_tready = 1'b1;
        push_exp(3);
        launch(3);
        wait_done(1, 400, seen);
        checks++; if (!seen) begin errors++; $display("FAIL multi_done: got timeout expected done pulse"); end
        checks++; if (beat_cnt !== 48) begin errors++; $display("FAIL multi_beats: got %0d expected 48", beat_cnt); end
        checks++; if (wi_count !== 16'd3) begin errors++; $display("FAIL multi_wi: got %0d expected 3", wi_count); end
        checks++; if (max_out > FDEPTH) begin errors++; $display("FAIL multi_depth: got %0d expected <= %0d", max_out, FDEPTH); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL multi_hold: got %0d expected 0", hold_err); end
        for (int i = 0; i < beat_cnt && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL multi_data[%0d]: got %0h expected %0h", i, got[i], e); end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        logic [W-1:0] e;
        apply_reset();
        bus.m_tready = 1'b0;
        push_exp(1);
        launch(1);
        repeat (20) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++; if (rd_cnt !== FDEPTH) begin errors++; $display("FAIL bp_reads: got %0d expected %0d", rd_cnt, FDEPTH); end
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b expected 0", bus.mem_rd_en); end
        checks++; if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== mem_word(0)) begin errors++; $display("FAIL bp_head: got %b/%0h expected 1/%0h", bus.m_tvalid, bus.m_tdata, mem_word(0)); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL bp_hold: got %0d expected 0", hold_err); end
        wait_done(0, 200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL bp_done: got timeout expected done pulse"); end
        checks++; if (beat_cnt !== 16) begin errors++; $display("FAIL bp_beats: got %0d expected 16", beat_cnt); end
        for (int i = 0; i < beat_cnt && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, got[i], e); end
        end
    endtask

    task automatic test_zero();
        apply_reset();
        bus.m_tready = 1'b1;
        launch(0);
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL zero_rd_en: got %b expected 0", bus.mem_rd_en); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_idle: got done=%b busy=%b expected 0 0", done, busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", rd_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [W-1:0] e;
        apply_reset();
        bus.m_tready = 1'b1;
        push_exp(2);
        launch(2);
        repeat (10) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.mem_rd_en !== 1'b0 || bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_bus: got en=%b valid=%b expected 0 0", bus.mem_rd_en, bus.m_tvalid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (bus.mem_rd_addr !== '0 || wi_count !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt: got addr=%0h wi=%0d expected 0 0", bus.mem_rd_addr, wi_count); end
        rst_n = 1'b1;
        exp_q.delete();
        push_exp(1);
        launch(1);
        wait_done(0, 100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL mid_done: got timeout expected done pulse"); end
        checks++; if (beat_cnt !== 16) begin errors++; $display("FAIL mid_beats: got %0d expected 16", beat_cnt); end
        checks++; if (got[0] !== mem_word(0)) begin errors++; $display("FAIL mid_first: got %0h expected %0h", got[0], mem_word(0)); end
        for (int i = 0; i < beat_cnt && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL mid_data[%0d]: got %0h expected %0h", i, got[i], e); end
        end
    endtask

    task automatic test_start_ignored();
        bit seen;
        logic [W-1:0] e;
        apply_reset();
        bus.m_tready = 1'b1;
        push_exp(1);
        launch(1);
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        num_wi = 16'd3; start = 1'b1;
        wait_done(0, 100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL ign_done: got timeout expected done pulse"); end
        checks++; if (beat_cnt !== 16) begin errors++; $display("FAIL ign_beats: got %0d expected 16", beat_cnt); end
        checks++; if (wi_count !== 16'd1) begin errors++; $display("FAIL ign_wi: got %0d expected 1", wi_count); end
        for (int i = 0; i < beat_cnt && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++; if (got[i] !== e) begin errors++; $display("FAIL ign_data[%0d]: got %0h expected %0h", i, got[i], e); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_wi = '0;
        bus.m_tready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_multi_toggle();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ty_stream_loader.md
TY_STREAM_LOADER -- requirements
Module: ty_stream_loader

Interface
REQ-001 SHALL have parameter DATAW, default 32, meaning word width per input stream.
REQ-002 SHALL have parameter NINPUTS, default 2, meaning number of input arrays packed side by side.
REQ-003 SHALL have parameter SIZE, default 1024, meaning words per array (one work instance).
REQ-004 SHALL have parameter RDLAT, default 2, meaning fixed memory read latency in cycles, 1..4.
REQ-005 SHALL have parameter FDEPTH, default 8, meaning output FIFO depth, power of two, at least RDLAT+2.
REQ-006 clk  in  1  clock; reset rst_n, synchronous, active-low; clock clk.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 start  in  1  single-cycle run request.
REQ-009 num_wi  in  16  work instances to stream, sampled on accepted start.
REQ-010 mem_rd_en  out  1  memory read strobe.
REQ-011 mem_rd_addr  out  clog2(SIZE)  word address, common to all arrays.
REQ-012 mem_rd_data  in  NINPUTS*DATAW  packed read data, valid RDLAT cycles after mem_rd_en; array k in bits [k*DATAW +: DATAW].
REQ-013 m_tvalid  out  1  stream valid to kernel.
REQ-014 m_tdata  out  NINPUTS*DATAW  packed stream data to kernel.
REQ-015 m_tready  in  1  kernel ready.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on completion.
REQ-018 wi_count  out  16  completed work instances issued in the current run.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-020 IDLE: start=1 with num_wi>0 -> ISSUE; latch num_wi; clear address and wi_count.
REQ-021 IDLE: start=1 with num_wi=0 -> DONE directly; no reads issued.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 ISSUE: mem_rd_en=1 only when fifo_count + in_flight < FDEPTH (credit rule); the FIFO SHALL never overflow.
REQ-024 Each read SHALL advance the address by 1; from SIZE-1 it SHALL wrap to 0 and increment wi_count.
REQ-025 ISSUE SHALL move to DRAIN in the cycle after the read at address SIZE-1 that makes wi_count equal the latched num_wi.
REQ-026 An RDLAT-deep valid shift register SHALL capture mem_rd_data into the FIFO exactly RDLAT cycles after each strobe.
REQ-027 m_tvalid SHALL equal FIFO not-empty, with m_tdata the FIFO head; pop on m_tvalid && m_tready.
REQ-028 Simultaneous push and pop SHALL keep the count unchanged, including when the FIFO is full.
REQ-029 m_tdata SHALL be held stable while m_tvalid=1 and m_tready=0.
REQ-030 Minimum start-to-first-m_tvalid latency SHALL be RDLAT+1 cycles; with m_tready=1, throughput SHALL be one word per cycle.
REQ-031 DRAIN -> DONE when the FIFO is empty and in_flight=0.
REQ-032 DONE SHALL assert done for one cycle, then return to IDLE; wi_count SHALL hold until the next accepted start.
REQ-033 Word order on m_tdata SHALL be strictly ascending address, wrapping per work instance.

Reset
REQ-034 On rst_n=0 at a clock edge: state IDLE; mem_rd_en, m_tvalid, busy and done all 0; mem_rd_addr 0; wi_count 0; FIFO empty; shift register cleared.
REQ-035 Reset during ISSUE or DRAIN SHALL discard in-flight reads; no stale word SHALL appear after reset.

Structure
REQ-036 A shared package ty_stream_pkg SHALL hold the FSM state enum, the default DATAW, NINPUTS and SIZE constants, and the clog2 helper.
REQ-037 The FIFO SHALL be the sub-module ty_sync_fifo, parameterised by width and depth, exposing a count output.

Verification
REQ-038 SIZE=16, num_wi=1, m_tready=1, memory word = {addr+1, addr+1} -> 16 beats with data 1..16 in order; done 1 cycle after the last beat drains; wi_count=1.
REQ-039 num_wi=3, m_tready toggling 1/0 -> 48 beats with addresses 0..15 repeated three times; no loss or duplication; FIFO count never exceeds FDEPTH.
REQ-040 m_tready=0 for 20 cycles after start -> exactly FDEPTH reads issued; mem_rd_en then low; m_tdata stable; stream resumes correctly on release.
REQ-041 start with num_wi=0 -> done 1 cycle later; mem_rd_en never asserted.
REQ-042 rst_n low for 1 cycle mid-ISSUE, then restart with num_wi=1 -> first beat is address 0; all outputs at reset values during reset.
REQ-043 start pulsed again during ISSUE -> ignored; beat count unchanged.
